// File: rtl/uart_pkg.sv
// Shared types and line constants for the UART transmitter (and a future receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Encoding 2'b11 is reserved and behaves as no parity.
  function automatic parity_mode_e decode_parity(input logic [1:0] m);
    return (m == 2'b11) ? PAR_NONE : parity_mode_e'(m);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: latches the divisor on restart, pulses bit_end on the last clk of each bit.
module baud_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  output logic             bit_end
);

  logic [DIV_W-1:0] div_q, cnt, last;

  // A divisor of zero is a one-cycle bit.
  assign last    = (div_q == '0) ? '0 : div_q - 1'b1;
  assign bit_end = en && (cnt == last);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (restart) begin
      cnt   <= '0;
      div_q <= div_in;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start / DATA_W bits LSB first / optional parity / 1-2 stop bits.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic [DIV_W-1:0]  baud_div,
  output logic              tx_out,
  output logic              busy
);

  localparam int               IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_e         state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx, src_data;
  logic [IDX_W-1:0]  idx;
  logic [DIV_W-1:0]  src_div;
  logic [1:0]        src_mode;
  logic              src_two, stop_idx, two_stop_q, par_bit, tx_nx;
  parity_mode_e      par_q, src_par;
  logic              accept, launch, bit_end, frame_end;

  assign busy      = (state != IDLE);
  assign accept    = valid && ready;
  assign frame_end = (state == STOP) && bit_end && (stop_idx || !two_stop_q);
  assign src_par   = decode_parity(src_mode);

`ifdef UART_TX_HOLD_EN
  logic              hold_full, hold_two;
  logic [DATA_W-1:0] hold_data;
  logic [1:0]        hold_mode;
  logic [DIV_W-1:0]  hold_div;

  // A queued word wins over the input port when a frame finishes.
  assign ready    = !hold_full;
  assign launch   = (state == IDLE || frame_end) && (hold_full || accept);
  assign src_data = hold_full ? hold_data : data_in;
  assign src_mode = hold_full ? hold_mode : parity_mode;
  assign src_two  = hold_full ? hold_two  : two_stop;
  assign src_div  = hold_full ? hold_div  : baud_div;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_mode <= '0;
      hold_two  <= 1'b0;
      hold_div  <= '0;
    end else if (launch && hold_full) begin
      hold_full <= 1'b0;
    end else if (accept && !launch) begin
      hold_full <= 1'b1;
      hold_data <= data_in;
      hold_mode <= parity_mode;
      hold_two  <= two_stop;
      hold_div  <= baud_div;
    end
`else
  assign ready    = !busy;
  assign launch   = accept;
  assign src_data = data_in;
  assign src_mode = parity_mode;
  assign src_two  = two_stop;
  assign src_div  = baud_div;
`endif

  baud_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (launch),
    .en      (busy),
    .div_in  (src_div),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (launch) state_nx = START;
      START:   if (bit_end) state_nx = DATA;
      DATA:    if (bit_end && idx == LAST_IDX) state_nx = (par_q == PAR_NONE) ? STOP : PARITY;
      PARITY:  if (bit_end) state_nx = STOP;
      STOP:    if (frame_end) state_nx = launch ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // tx_out is registered, so the line value is derived from the next state and shifter.
  always_comb begin
    shreg_nx = shreg;
    if (launch)                     shreg_nx = src_data;
    else if (state == DATA && bit_end) shreg_nx = shreg >> 1;
    unique case (state_nx)
      START:   tx_nx = START_BIT;
      DATA:    tx_nx = shreg_nx[0];
      PARITY:  tx_nx = par_bit;
      default: tx_nx = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shreg      <= '0;
      tx_out     <= LINE_IDLE;
      idx        <= '0;
      stop_idx   <= 1'b0;
      par_q      <= PAR_NONE;
      two_stop_q <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      shreg  <= shreg_nx;
      tx_out <= tx_nx;
      if (launch) begin
        par_q      <= src_par;
        two_stop_q <= src_two;
        par_bit    <= (src_par == PAR_ODD) ? ~^src_data : ^src_data;
        idx        <= '0;
        stop_idx   <= 1'b0;
      end else begin
        if (state == DATA && bit_end) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        if (state == STOP && bit_end) stop_idx <= !frame_end;
      end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: expected serial frames are queued at issue and
// checked bit-by-bit by a monitor watching tx_out. Hold-register case needs UART_TX_HOLD_EN.
module tb_uart_tx_param;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic [1:0]        parity_mode;
  logic              two_stop;
  logic [DIV_W-1:0]  baud_div;
  logic              tx_out;
  logic              busy;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .valid       (valid),
    .ready       (ready),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .baud_div    (baud_div),
    .tx_out      (tx_out),
    .busy        (busy)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  string exp_bits[$];
  int    exp_d[$];
  logic  in_frame = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops one expected frame per start bit and checks every cycle of it.
  task automatic monitor();
    string cur;
    int    d, pos, len;
    forever begin
      @(negedge clk);
      if (!reset) in_frame = 1'b0;
      else begin
        if (!in_frame && tx_out === 1'b0) begin
          if (exp_bits.size() == 0) chk("unexpected_start", 32'(tx_out), 32'd1);
          else begin
            cur = exp_bits.pop_front();
            d   = exp_d.pop_front();
            pos = 0;
            len = cur.len() * d;
            in_frame = 1'b1;
          end
        end
        if (in_frame) begin
          chk($sformatf("frame_bit%0d", pos / d), 32'(tx_out), 32'(cur.getc(pos / d) == "1"));
          chk("busy_in_frame", 32'(busy), 32'd1);
          pos++;
          if (pos == len) in_frame = 1'b0;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                      input logic [15:0] bd, input string bits, input int bit_d,
                      output int waited);
    @(negedge clk);
    data_in = d; parity_mode = pm; two_stop = ts; baud_div = bd; valid = 1'b1;
    waited = 0;
    while (!ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    exp_bits.push_back(bits);
    exp_d.push_back(bit_d);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic count_busy(output int nb, output int nr);
    nb = 0; nr = 0;
    @(negedge clk);
    while (busy && nb < 5000) begin
      nb++;
      if (!ready) nr++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || in_frame || exp_bits.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy || in_frame), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w, nb, nr;
    data_in = '0; valid = 1'b0; parity_mode = 2'b00; two_stop = 1'b0; baud_div = '0;
    fork
      monitor();
      begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
      end
    join_none

    #12;
    chk("reset_tx", 32'(tx_out), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // 0xA5, even parity, D=4
    send(8'hA5, 2'b01, 1'b0, 16'd4, "01010010101", 4, w);
    count_busy(nb, nr);
    chk("t1_busy_len", nb, 44);
`ifndef UART_TX_HOLD_EN
    chk("t1_ready_low_len", nr, 44);
`endif
    wait_idle();

    // 0x00, odd parity, divisor 0 acts as 1
    send(8'h00, 2'b10, 1'b0, 16'd0, "00000000011", 1, w);
    count_busy(nb, nr);
    chk("t2_busy_len", nb, 11);
    wait_idle();

    // 0xFF, no parity, two stop bits, D=2; config changed mid-frame must be ignored
    send(8'hFF, 2'b00, 1'b1, 16'd2, "01111111111", 2, w);
    parity_mode = 2'b10; baud_div = 16'd7; two_stop = 1'b0;
    count_busy(nb, nr);
    chk("t3_busy_len", nb, 22);
    wait_idle();

    // second word presented while busy: held until ready, sent exactly once
    send(8'h81, 2'b00, 1'b0, 16'd2, "0100000011", 2, w);
    send(8'h3C, 2'b00, 1'b0, 16'd2, "0001111001", 2, w);
`ifdef UART_TX_HOLD_EN
    chk("t4_wait_cycles", w, 0);
`else
    chk("t4_wait_cycles", w, 20);
`endif
    wait_idle();
    repeat (40) @(negedge clk);
    chk("t4_no_extra_frame", exp_bits.size(), 0);
    chk("t4_line_idle", 32'(tx_out), 32'd1);

    // async reset during data bit 3 of 0x00 (D=4, no parity)
    send(8'h00, 2'b00, 1'b0, 16'd4, "00000000001", 4, w);
    repeat (18) @(posedge clk);
    #2;
    chk("t5_pre_tx", 32'(tx_out), 32'd0);
    reset = 1'b0;
    #1;
    chk("t5_rst_tx", 32'(tx_out), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", 32'(ready), 32'd1);
    send(8'hC3, 2'b01, 1'b0, 16'd1, "01100001101", 1, w);
    count_busy(nb, nr);
    chk("t5_busy_len", nb, 11);
    wait_idle();

`ifdef UART_TX_HOLD_EN
    // back-to-back through the holding register, D=3, no parity
    send(8'h12, 2'b00, 1'b0, 16'd3, "0010010001", 3, w);
    fork
      count_busy(nb, nr);
      begin
        send(8'h34, 2'b00, 1'b0, 16'd3, "0001011001", 3, w);
        chk("t6_ready_after_2nd", 32'(ready), 32'd0);
      end
    join
    chk("t6_busy_len", nb, 60);
    wait_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
